// File: rtl/inst_queue_s.sv
// ---------------------------------------------------------------------------
// inst_queue_s
//
// Queue and issuer for 12-bit device instructions. It sits directly upstream
// of the two-register bank. Upstream writes instructions over a valid/ready
// handshake. Buffered entries are replayed in strict FIFO order as a
// registered out_inst / out_inst_en strobe stream.
//
// Issue timing:
//   - A programmable number of idle cycles (Gap) follows every issue.
//   - The stall input blocks issue in any cycle it is high.
//
// Opcode screening: the opcode is in bits [11:8]. An opcode above MaxCode at
// the head of the queue is never issued. It moves the block into a sticky
// Error state and flushes the queue. Only reset leaves the Error state.
//
// Parameters:
//   Depth    queue entries (power of two, >= 2)
//   Gap      idle cycles forced after each issue (0..255)
//   MaxCode  highest legal opcode in bits [11:8]
//
// Ports:
//   clock        single clock, all logic on its rising edge
//   reset        synchronous, active-low reset
//   in_inst      instruction from upstream
//   in_valid     in_inst is valid this cycle
//   in_ready     queue can accept (Ready state and not full)
//   stall        no issue while high
//   out_inst     instruction to the bank (registered)
//   out_inst_en  one-cycle issue strobe (registered)
//   error        high while in the Error state
//   occupancy    registered entry count; present only with
//                INSTQUEUES_OCCUPANCY_EN defined
//
// Optional feature macro: INSTQUEUES_OCCUPANCY_EN
// ---------------------------------------------------------------------------
module inst_queue_s #(
  parameter int Depth   = 4,
  parameter int Gap     = 0,
  parameter int MaxCode = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [11:0]           in_inst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  output logic [11:0]           out_inst,
  output logic                  out_inst_en,
  output logic                  error
`ifdef INSTQUEUES_OCCUPANCY_EN
  ,
  output logic [$clog2(Depth):0] occupancy
`endif
);

  localparam int              PtrW    = $clog2(Depth);
  localparam logic [PtrW:0]   Full    = (PtrW+1)'(Depth);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
  localparam logic [7:0]      GapLoad = 8'(Gap);
  // Opcodes are 4 bits wide, so any MaxCode of 15 or more makes every opcode legal.
  localparam logic [3:0]      CodeMax = (MaxCode >= 15) ? 4'hF : 4'(MaxCode);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_READY,
    ST_ERROR
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [11:0]     mem [Depth];
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [PtrW:0]   count;
  logic [7:0]      gap_cnt;

  logic [11:0]     head_inst;
  logic            push;
  logic            issue;
  logic            pop;
  logic            flush;

  // The full test uses the count from before the edge. A full queue therefore
  // refuses a push even in a cycle where it also pops.
  assign in_ready  = (state == ST_READY) && (count != Full);
  assign error     = (state == ST_ERROR);
  assign push      = in_valid && in_ready;
  assign head_inst = mem[head];

  // The issue slot opens only in Ready, with data present, no stall and the
  // gap expired. A legal head is popped. An illegal head flushes the queue.
  assign issue = (state == ST_READY) && (count != '0) && !stall && (gap_cnt == 8'd0);
  assign pop   = issue && (head_inst[11:8] <= CodeMax);
  assign flush = issue && !pop;

`ifdef INSTQUEUES_OCCUPANCY_EN
  // count is held at zero in Reset and Error, so it can be exported directly.
  assign occupancy = count;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_READY;
      ST_READY: if (flush) state_next = ST_ERROR;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RESET;
    endcase
  end

  // Entry storage has no reset. The pointers and count decide what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= in_inst;
    end
  end

  // Pointer and count bookkeeping.
  // A flush discards everything, including a push accepted at the same edge.
  // The Error state keeps the queue empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PtrOne;
      if (pop)  head <= head + PtrOne;
      case ({push, pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

  // The gap counter reloads on every issue. It otherwise counts down freely,
  // whether or not the queue is stalled or empty. A pop can only happen when
  // the counter is already zero, so reload and count-down never collide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gap_cnt <= 8'd0;
    end else if (pop) begin
      gap_cnt <= GapLoad;
    end else if (gap_cnt != 8'd0) begin
      gap_cnt <= gap_cnt - 8'd1;
    end
  end

  // Registered outputs to the bank.
  // - out_inst holds its last value between issues.
  // - out_inst is cleared when the Error state is entered and stays zero
  //   there, because nothing issues again until reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_inst    <= 12'h000;
      out_inst_en <= 1'b0;
    end else begin
      out_inst_en <= pop;
      if (pop) begin
        out_inst <= head_inst;
      end else if (flush) begin
        out_inst <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue_s.sv
// ---------------------------------------------------------------------------
// tb_inst_queue_s
//
// Bench for inst_queue_s. Two copies of the queue share the same input
// stimulus: one built with Gap=0 and one with Gap=2.
//
// Reference model: each copy has its own behavioural model, built from a
// shifting array, a size and a gap countdown. The model advances on every
// rising edge.
//
// Per-cycle check: on every falling edge, checkOutput compares all outputs of
// both copies against their models.
//
// Directed scenarios record each copy's strobes. Their values and spacing are
// then checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_inst_queue_s;

  localparam int DEPTH   = 4;
  localparam int MAXCODE = 3;
  localparam int LOGN    = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] in_inst;
  logic        in_valid;
  logic        stall;

  logic [1:0]  rdy;
  logic [1:0]  en;
  logic [1:0]  err;
  logic [11:0] oinst [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

`ifdef INSTQUEUES_OCCUPANCY_EN
  logic [2:0] occ [2];
`endif

  inst_queue_s #(.Depth(DEPTH), .Gap(0), .MaxCode(MAXCODE)) dut_g0 (
    .clock       (clock),
    .reset       (reset),
    .in_inst     (in_inst),
    .in_valid    (in_valid),
    .in_ready    (rdy[0]),
    .stall       (stall),
    .out_inst    (oinst[0]),
    .out_inst_en (en[0]),
    .error       (err[0])
`ifdef INSTQUEUES_OCCUPANCY_EN
    ,
    .occupancy   (occ[0])
`endif
  );

  inst_queue_s #(.Depth(DEPTH), .Gap(2), .MaxCode(MAXCODE)) dut_g2 (
    .clock       (clock),
    .reset       (reset),
    .in_inst     (in_inst),
    .in_valid    (in_valid),
    .in_ready    (rdy[1]),
    .stall       (stall),
    .out_inst    (oinst[1]),
    .out_inst_en (en[1]),
    .error       (err[1])
`ifdef INSTQUEUES_OCCUPANCY_EN
    ,
    .occupancy   (occ[1])
`endif
  );

  // -------------------------------------------------------------------------
  // Behavioural model: one queue per copy, indexed by k (0 -> Gap 0, 1 -> Gap 2)
  // -------------------------------------------------------------------------
  typedef enum {M_RESET, M_READY, M_ERROR} mstate_t;

  mstate_t     ms   [2];
  logic [11:0] mq   [2][DEPTH];
  int          msz  [2];
  int          mgap [2];
  logic [11:0] minst[2];
  logic        men  [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic modelStep(input int k);
    bit can_push;
    bit slot;
    if (!reset) begin
      ms[k]    = M_RESET;
      msz[k]   = 0;
      mgap[k]  = 0;
      minst[k] = 12'h000;
      men[k]   = 1'b0;
    end else begin
      case (ms[k])
        M_RESET: begin
          ms[k]  = M_READY;
          men[k] = 1'b0;
        end
        M_READY: begin
          can_push = in_valid && (msz[k] < DEPTH);
          slot     = (msz[k] > 0) && !stall && (mgap[k] == 0);
          if (mgap[k] > 0) mgap[k]--;
          men[k] = 1'b0;
          if (slot) begin
            if (int'(mq[k][0][11:8]) <= MAXCODE) begin
              minst[k] = mq[k][0];
              men[k]   = 1'b1;
              for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i+1];
              msz[k]--;
              mgap[k] = gap_of(k);
            end else begin
              ms[k]    = M_ERROR;
              msz[k]   = 0;
              minst[k] = 12'h000;
              can_push = 1'b0;
            end
          end
          if (can_push) begin
            mq[k][msz[k]] = in_inst;
            msz[k]++;
          end
        end
        default: begin
          men[k]   = 1'b0;
          minst[k] = 12'h000;
        end
      endcase
    end
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) modelStep(k);
  end

  // -------------------------------------------------------------------------
  // Checking helpers and strobe log
  // -------------------------------------------------------------------------
  logic [11:0] slog [2][LOGN];
  int          scyc [2][LOGN];
  int          scnt [2];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    logic exp_rdy;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = (ms[k] == M_READY) && (msz[k] < DEPTH);
      cmp($sformatf("g%0d_in_ready", gap_of(k)),    32'(rdy[k]),   32'(exp_rdy));
      cmp($sformatf("g%0d_error", gap_of(k)),       32'(err[k]),   32'(ms[k] == M_ERROR));
      cmp($sformatf("g%0d_out_inst_en", gap_of(k)), 32'(en[k]),    32'(men[k]));
      cmp($sformatf("g%0d_out_inst", gap_of(k)),    32'(oinst[k]), 32'(minst[k]));
`ifdef INSTQUEUES_OCCUPANCY_EN
      cmp($sformatf("g%0d_occupancy", gap_of(k)),   32'(occ[k]),   32'(msz[k]));
`endif
      if (en[k] === 1'b1 && scnt[k] < LOGN) begin
        slog[k][scnt[k]] = oinst[k];
        scyc[k][scnt[k]] = cyc;
        scnt[k]++;
      end
    end
  endtask

  // Drive one cycle of inputs, then check at the following falling edge.
  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic [11:0] d);
    reset    = r;
    in_valid = v;
    stall    = s;
    in_inst  = d;
    @(negedge clock);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int          a;
    int          b0;
    int          b1;
    logic [11:0] seq3 [3];
    logic [11:0] seq5 [5];
    logic [3:0]  op;
    logic        r;
    logic        v;
    logic        s;

    scnt[0]  = 0;
    scnt[1]  = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    in_inst  = 12'h000;
    $display("[TB] start");
    @(negedge clock);

    // Reset held low for three edges, then released
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    reset = 1'b1;
    cmp("rst_ready_low_g0",  32'(rdy[0]),   32'd0);
    cmp("rst_ready_low_g2",  32'(rdy[1]),   32'd0);
    cmp("rst_out_inst_g0",   32'(oinst[0]), 32'h000);
    cmp("rst_out_en_g0",     32'(en[0]),    32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    cmp("rst_ready_high_g0", 32'(rdy[0]),   32'd1);
    cmp("rst_ready_high_g2", 32'(rdy[1]),   32'd1);
    idle(2);

    // Back-to-back issue: 2AB, 355, 101 on consecutive cycles
    seq3 = '{12'h2AB, 12'h355, 12'h101};
    a  = cyc + 1;
    b0 = scnt[0];
    b1 = scnt[1];
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, seq3[i]);
    idle(12);
    cmp("b2b_count_g0", 32'(scnt[0] - b0), 32'd3);
    cmp("b2b_count_g2", 32'(scnt[1] - b1), 32'd3);
    if (scnt[0] - b0 == 3) begin
      cmp("b2b_first_cycle_g0", 32'(scyc[0][b0]), 32'(a + 1));
      for (int i = 0; i < 3; i++) begin
        cmp($sformatf("b2b_value%0d_g0", i), 32'(slog[0][b0+i]), 32'(seq3[i]));
        cmp($sformatf("b2b_spacing%0d_g0", i), 32'(scyc[0][b0+i] - scyc[0][b0]), 32'(i));
      end
    end
    if (scnt[1] - b1 == 3) begin
      for (int i = 0; i < 3; i++) begin
        cmp($sformatf("b2b_value%0d_g2", i), 32'(slog[1][b1+i]), 32'(seq3[i]));
        cmp($sformatf("b2b_spacing%0d_g2", i), 32'(scyc[1][b1+i] - scyc[1][b1]), 32'(3 * i));
      end
    end

    // Gap spacing: 211 and 322 pushed together
    b0 = scnt[0];
    b1 = scnt[1];
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h211);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h322);
    idle(10);
    cmp("gap_count_g2", 32'(scnt[1] - b1), 32'd2);
    if (scnt[1] - b1 == 2) begin
      cmp("gap_value0_g2", 32'(slog[1][b1]),   32'h211);
      cmp("gap_value1_g2", 32'(slog[1][b1+1]), 32'h322);
      cmp("gap_spacing_g2", 32'(scyc[1][b1+1] - scyc[1][b1]), 32'd3);
    end
    if (scnt[0] - b0 == 2) begin
      cmp("gap_spacing_g0", 32'(scyc[0][b0+1] - scyc[0][b0]), 32'd1);
    end

    // Full queue under stall, fifth entry held by upstream
    seq5 = '{12'h1A1, 12'h0B2, 12'h2C3, 12'h3D4, 12'h1E5};
    b0 = scnt[0];
    b1 = scnt[1];
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, seq5[i]);
    cmp("full_ready_g0", 32'(rdy[0]), 32'd0);
    cmp("full_ready_g2", 32'(rdy[1]), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, seq5[4]);
    applyStimulus(1'b1, 1'b1, 1'b1, seq5[4]);
    cmp("full_held_ready_g0", 32'(rdy[0]), 32'd0);
    cmp("full_held_en_g0",    32'(en[0]),  32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, seq5[4]);
    cmp("full_release_ready_g0", 32'(rdy[0]), 32'd1);
    cmp("full_release_ready_g2", 32'(rdy[1]), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, seq5[4]);
    idle(20);
    cmp("full_count_g0", 32'(scnt[0] - b0), 32'd5);
    cmp("full_count_g2", 32'(scnt[1] - b1), 32'd5);
    if (scnt[0] - b0 == 5) begin
      for (int i = 0; i < 5; i++)
        cmp($sformatf("full_order%0d_g0", i), 32'(slog[0][b0+i]), 32'(seq5[i]));
    end
    if (scnt[1] - b1 == 5) begin
      for (int i = 0; i < 5; i++)
        cmp($sformatf("full_order%0d_g2", i), 32'(slog[1][b1+i]), 32'(seq5[i]));
    end

    // Illegal opcode: 2AA issues, 4FF triggers Error, 3BB is never seen
    b0 = scnt[0];
    b1 = scnt[1];
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h2AA);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h4FF);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h3BB);
    idle(12);
    cmp("illegal_count_g0", 32'(scnt[0] - b0), 32'd1);
    cmp("illegal_count_g2", 32'(scnt[1] - b1), 32'd1);
    if (scnt[0] - b0 == 1) cmp("illegal_value_g0", 32'(slog[0][b0]), 32'h2AA);
    if (scnt[1] - b1 == 1) cmp("illegal_value_g2", 32'(slog[1][b1]), 32'h2AA);
    cmp("illegal_error_g0",    32'(err[0]),   32'd1);
    cmp("illegal_error_g2",    32'(err[1]),   32'd1);
    cmp("illegal_ready_g0",    32'(rdy[0]),   32'd0);
    cmp("illegal_out_inst_g0", 32'(oinst[0]), 32'h000);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    cmp("illegal_reset_error_g0", 32'(err[0]), 32'd0);
    cmp("illegal_reset_error_g2", 32'(err[1]), 32'd0);
    b0 = scnt[0];
    idle(6);
    cmp("illegal_reset_empty_g0", 32'(scnt[0] - b0), 32'd0);
    cmp("illegal_reset_ready_g0", 32'(rdy[0]), 32'd1);

    // Reset in the middle of traffic while Gap=2 copy is mid-gap
    b0 = scnt[0];
    b1 = scnt[1];
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h111);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h122);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h133);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    cmp("midrst_en_g0",    32'(en[0]),  32'd0);
    cmp("midrst_en_g2",    32'(en[1]),  32'd0);
    cmp("midrst_ready_g0", 32'(rdy[0]), 32'd0);
    idle(10);
    cmp("midrst_strobes_g0", 32'(scnt[0] - b0), 32'd2);
    cmp("midrst_strobes_g2", 32'(scnt[1] - b1), 32'd1);

    // Randomized traffic against the models
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 149) != 0);
      v  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 3) == 0);
      op = ($urandom_range(0, 127) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      applyStimulus(r, v, s, {op, 8'($urandom)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
